// File: rtl/vol_scale_seq.sv
// Serial voltage-scaling sequencer: arbitrates per-domain level requests round-robin
// and drives a single shared regulator through a 4-phase handshake.
module vol_scale_seq #(
   parameter int NUM_PD      = 6,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                aopd_clk_32k,
   input  logic                aopd_rtc_rstn,
   input  logic [NUM_PD-1:0]   pd_vol_scale_req,
   input  logic [3*NUM_PD-1:0] pd_vol_scale,
   output logic [NUM_PD-1:0]   pd_vol_scale_ack,
   output logic [NUM_PD-1:0]   pd_vol_on,
   output logic                reg_req,
   output logic [2:0]          reg_pd_sel,
   output logic [2:0]          reg_level,
   input  logic                reg_ack,
   output logic                busy,
   output logic                timeout_err
);
   localparam int IW      = (NUM_PD > 1) ? $clog2(NUM_PD) : 1;
   localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {IDLE, PROG, REL, SETTLE, ACK} state_t;

   state_t                   state;
   logic [NUM_PD-1:0]        sync1, sreq;
   logic [IW-1:0]            ptr, sel, gidx;
   logic [NUM_PD-1:0][2:0]   cur_lvl, lvl_in;
   logic [CW-1:0]            cnt;
   logic                     found, tmo;

   assign lvl_in     = pd_vol_scale;
   assign reg_pd_sel = 3'(sel);
   assign busy       = (state != IDLE);
   assign tmo        = (cnt == CW'(TIMEOUT_CYC - 1));

   // first pending synchronized request at or after ptr, wrapping
   always_comb begin
      logic [3:0] sum;
      sum   = '0;
      found = 1'b0;
      gidx  = '0;
      for (int k = 0; k < NUM_PD; k++) begin
         sum = 4'(ptr) + 4'(k);
         if (sum >= 4'(NUM_PD)) sum = sum - 4'(NUM_PD);
         if (!found && sreq[sum[IW-1:0]] && !pd_vol_scale_ack[sum[IW-1:0]]) begin
            found = 1'b1;
            gidx  = sum[IW-1:0];
         end
      end
   end

   always_ff @(posedge aopd_clk_32k or negedge aopd_rtc_rstn) begin
      if (!aopd_rtc_rstn) begin
         state            <= IDLE;
         sync1            <= '0;
         sreq             <= '0;
         ptr              <= '0;
         sel              <= '0;
         cur_lvl          <= '0;
         cnt              <= '0;
         pd_vol_scale_ack <= '0;
         pd_vol_on        <= '1;
         reg_req          <= 1'b0;
         reg_level        <= '0;
         timeout_err      <= 1'b0;
      end else begin
         sync1       <= pd_vol_scale_req;
         sreq        <= sync1;
         timeout_err <= 1'b0;
         unique case (state)
            IDLE: if (found) begin
               sel       <= gidx;
               reg_level <= lvl_in[gidx];
               ptr       <= (int'(gidx) == NUM_PD - 1) ? '0 : gidx + 1'b1;
               if (lvl_in[gidx] == cur_lvl[gidx]) begin
                  state                  <= ACK;
                  pd_vol_scale_ack[gidx] <= 1'b1;
               end else begin
                  state           <= PROG;
                  reg_req         <= 1'b1;
                  pd_vol_on[gidx] <= 1'b0;
                  cnt             <= '0;
               end
            end
            PROG: if (reg_ack) begin
               state   <= REL;
               reg_req <= 1'b0;
               cnt     <= '0;
            end else if (tmo) begin
               state                 <= ACK;
               reg_req               <= 1'b0;
               timeout_err           <= 1'b1;
               pd_vol_on[sel]        <= 1'b1;
               pd_vol_scale_ack[sel] <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
            REL: if (!reg_ack) begin
               state        <= SETTLE;
               cur_lvl[sel] <= reg_level;
               cnt          <= '0;
            end else if (tmo) begin
               // regulator never released: level is not trusted, cur_lvl kept
               state                 <= ACK;
               timeout_err           <= 1'b1;
               pd_vol_on[sel]        <= 1'b1;
               pd_vol_scale_ack[sel] <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
            SETTLE: if (cnt == CW'(SETTLE_CYC - 1)) begin
               state                 <= ACK;
               pd_vol_on[sel]        <= 1'b1;
               pd_vol_scale_ack[sel] <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
            ACK: if (!sreq[sel]) begin
               state                 <= IDLE;
               pd_vol_scale_ack[sel] <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/vol_scale_seq.md
VOL_SCALE_SEQ -- requirements
Module: vol_scale_seq

Interface
REQ-001 Parameter NUM_PD, default 6, number of requesting power domains (1..8).
REQ-002 Parameter SETTLE_CYC, default 16, post-regulator settle time in clock cycles (>=1).
REQ-003 Parameter TIMEOUT_CYC, default 255, regulator handshake timeout in clock cycles (>=2).
REQ-004 aopd_clk_32k  input  1  sole clock (32 kHz always-on); one clock, all state on its rising edge.
REQ-005 aopd_rtc_rstn  input  1  reset; asynchronous assert, active-low.
REQ-006 pd_vol_scale_req  input  NUM_PD  per-domain 4-phase request, pclk domain (asynchronous).
REQ-007 pd_vol_scale  input  3*NUM_PD  target level; domain i at bits [3i+2:3i]; stable while its req is high.
REQ-008 pd_vol_scale_ack  output  NUM_PD  per-domain 4-phase acknowledge.
REQ-009 pd_vol_on  output  NUM_PD  1 = domain voltage stable.
REQ-010 reg_req  output  1  4-phase request to the shared regulator.
REQ-011 reg_pd_sel  output  3  domain index being programmed.
REQ-012 reg_level  output  3  level being programmed.
REQ-013 reg_ack  input  1  regulator acknowledge, same clock domain.
REQ-014 busy  output  1  high whenever FSM is not IDLE.
REQ-015 timeout_err  output  1  one-cycle pulse on regulator timeout.

Function
REQ-016 Each pd_vol_scale_req bit SHALL pass a 2-flop synchronizer; logic uses only synchronized req (sreq).
REQ-017 FSM states SHALL be IDLE, PROG, REL, SETTLE, ACK.
REQ-018 In IDLE with any sreq high and ack low, the block SHALL grant one domain round-robin: search starts at pointer ptr (reset 0); after grant g, ptr = (g+1) mod NUM_PD.
REQ-019 On grant, level of g SHALL be captured into reg_level and g into reg_pd_sel; these hold until the next grant.
REQ-020 Per-domain current-level register cur_lvl[i] (reset 3'd0) SHALL record the last successfully programmed level.
REQ-021 If captured level equals cur_lvl[g], IDLE SHALL go directly to ACK; reg_req and pd_vol_on[g] unaffected.
REQ-022 Otherwise IDLE->PROG: reg_req=1, pd_vol_on[g]=0 from the grant cycle.
REQ-023 PROG: on reg_ack=1 -> REL with reg_req=0.
REQ-024 REL: on reg_ack=0 -> SETTLE; cur_lvl[g] updated to reg_level on this transition.
REQ-025 SETTLE SHALL last exactly SETTLE_CYC cycles, then -> ACK with pd_vol_on[g]=1 in the first ACK cycle.
REQ-026 ACK: pd_vol_scale_ack[g]=1 until sreq[g]=0 is observed, then ack[g]=0 and -> IDLE in the same edge.
REQ-027 A new grant SHALL NOT occur in the cycle the FSM returns to IDLE from ACK; earliest next grant is one cycle later.
REQ-028 Timeout counter SHALL reset on entry to PROG and REL; if it reaches TIMEOUT_CYC in either state: reg_req=0, timeout_err pulses one cycle, cur_lvl[g] unchanged, pd_vol_on[g]=1, -> ACK.
REQ-029 At most one ack bit and at most one domain with pd_vol_on=0 at any time.
REQ-030 Requests arriving while busy SHALL be held pending (level sampled at grant, not arrival); none lost.
REQ-031 A domain whose sreq drops before grant SHALL not be granted.
REQ-032 Only one FSM instance; regulator shared serially across all domains.

Reset
REQ-033 Reset SHALL force: FSM IDLE, ptr 0, cur_lvl all 0, synchronizers 0, pd_vol_scale_ack 0, pd_vol_on all 1, reg_req 0, reg_pd_sel 0, reg_level 0, busy 0, timeout_err 0.
REQ-034 Reset asserted mid-transaction SHALL abort immediately with the values above; no ack or timeout_err emitted afterward.

Verification
REQ-035 Single request: pd2 req, level 3'd5, reg_ack 3 cycles after reg_req -> reg_pd_sel=2, reg_level=5, pd_vol_on[2]=0 until SETTLE_CYC=16 expire, then ack[2]; cur_lvl[2]=5.
REQ-036 Same level: pd2 re-requests 3'd5 -> ack[2] without reg_req, pd_vol_on[2] stays 1.
REQ-037 Round-robin: pd0,pd3,pd5 req simultaneously from reset -> grant order 0,3,5; then pd0,pd5 again with ptr=0 -> order 0,5.
REQ-038 Timeout: reg_ack tied 0 -> reg_req drops after 255 cycles in PROG, one-cycle timeout_err, ack issued, cur_lvl unchanged.
REQ-039 Reset during SETTLE of pd4 -> all pd_vol_on=1, ack=0, reg_req=0 immediately; later pd4 request re-programs from cur_lvl=0.
REQ-040 Withdrawal: pd1 req pulses high then low while pd3 being serviced -> pd1 never granted, no ack[1].
